rename_stage_2w: RTL and testbench

// Two-lane decode-to-dispatch rename stage: ARF (value/busy/tag) plus circular rename file (RRF), parametrised width and depth.

---
 rtl/rename_pkg.sv | 25 ++
 rtl/rename_stage_2w_rrf_alloc_ctrl.sv | 54 +++++
 rtl/rename_stage_2w.sv | 260 ++++++++++++++++++++++++++
 tb/tb_rename_stage_2w.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// rtl/rename_pkg.sv - shared defaults, tag-width helper and operand/lane typedefs for the rename stage
package rename_pkg;

  localparam int DEF_XLEN      = 32;
  localparam int DEF_NUM_ARCH  = 32;
  localparam int DEF_RRF_DEPTH = 16;

  function automatic int tag_w(input int depth);
    return $clog2(depth);
  endfunction

  typedef struct packed {
    logic                rdy;
    logic [DEF_XLEN-1:0] val;
  } operand_t;

  typedef struct packed {
    operand_t                         op1;
    operand_t                         op2;
    logic [$clog2(DEF_RRF_DEPTH)-1:0] rd_tag;
    logic [4:0]                       rd;
    logic                             wr;
  } lane_out_t;

endpackage

// File: rtl/rename_stage_2w_rrf_alloc_ctrl.sv
// rtl/rename_stage_2w_rrf_alloc_ctrl.sv - RRF ring pointers: head/tail/count update and free-space compare
module rrf_alloc_ctrl
  import rename_pkg::*;
#(
  parameter  int RRF_DEPTH = DEF_RRF_DEPTH,
  localparam int TAG_W     = tag_w(RRF_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic [1:0]       need_i,
  input  logic [1:0]       alloc_n_i,
  input  logic [1:0]       retire_n_i,
  output logic [TAG_W-1:0] head_o,
  output logic [TAG_W-1:0] tail_o,
  output logic [TAG_W:0]   count_o,
  output logic             space_ok_o
);

  localparam logic [TAG_W:0] DEPTH = (TAG_W+1)'(RRF_DEPTH);

  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  // Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    head_d  = head_q + TAG_W'(retire_n_i);
    tail_d  = tail_q + TAG_W'(alloc_n_i);
    count_d = count_q + (TAG_W+1)'(alloc_n_i) - (TAG_W+1)'(retire_n_i);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o     = head_q;
  assign tail_o     = tail_q;
  assign count_o    = count_q;
  assign space_ok_o = (DEPTH - count_q) >= (TAG_W+1)'(need_i);

endmodule

// File: rtl/rename_stage_2w.sv
// rtl/rename_stage_2w.sv - two-lane rename stage: ARF, circular RRF, operand read, registered dispatch output
// Optional RENAME_STATS_EN adds saturating allocation/stall/full counters.
module rename_stage_2w
  import rename_pkg::*;
#(
  parameter  int XLEN      = DEF_XLEN,
  parameter  int NUM_ARCH  = DEF_NUM_ARCH,
  parameter  int RRF_DEPTH = DEF_RRF_DEPTH,
  localparam int TAG_W     = tag_w(RRF_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_valid_b,
  output logic             in_ready,
  input  logic [4:0]       rs1_a,
  input  logic [4:0]       rs2_a,
  input  logic [4:0]       rd_a,
  input  logic             wr_a,
  input  logic [4:0]       rs1_b,
  input  logic [4:0]       rs2_b,
  input  logic [4:0]       rd_b,
  input  logic             wr_b,
  input  logic [1:0]       cmp_en,
  input  logic [TAG_W-1:0] cmp_tag0,
  input  logic [TAG_W-1:0] cmp_tag1,
  input  logic [XLEN-1:0]  cmp_data0,
  input  logic [XLEN-1:0]  cmp_data1,
  output logic             out_valid,
  output logic             out_valid_b,
  input  logic             out_ready,
  output logic [XLEN:0]    out_op1_a,
  output logic [XLEN:0]    out_op2_a,
  output logic [XLEN:0]    out_op1_b,
  output logic [XLEN:0]    out_op2_b,
  output logic [TAG_W-1:0] out_rd_tag_a,
  output logic [TAG_W-1:0] out_rd_tag_b,
  output logic [4:0]       out_rd_a,
  output logic [4:0]       out_rd_b,
  output logic             out_wr_a,
  output logic             out_wr_b,
  output logic [1:0]       retire_cnt,
  output logic [4:0]       retire_rd0,
  output logic [4:0]       retire_rd1
`ifdef RENAME_STATS_EN
  ,
  output logic [31:0]      stat_alloc,
  output logic [31:0]      stat_stall,
  output logic [31:0]      stat_full
`endif
);

  logic [XLEN-1:0]      arf_val_q [NUM_ARCH];
  logic [TAG_W-1:0]     arf_tag_q [NUM_ARCH];
  logic [NUM_ARCH-1:0]  arf_busy_q;
  logic [XLEN-1:0]      rrf_val_q [RRF_DEPTH];
  logic [4:0]           rrf_rd_q  [RRF_DEPTH];
  logic [RRF_DEPTH-1:0] rrf_cmp_q;

  logic [TAG_W-1:0] head, tail, head_p1, tag_a, tag_b;
  logic [TAG_W:0]   count;
  logic             need_a, need_b, space_ok, accept, ret0, ret1;
  logic [1:0]       need, alloc_n, retire_n;
  logic [4:0]       ret_rd0, ret_rd1;
  logic [XLEN:0]    op1_a, op2_a, op1_b, op2_b;

  logic             out_valid_q, out_valid_b_q, out_wr_a_q, out_wr_b_q;
  logic [XLEN:0]    op1_a_q, op2_a_q, op1_b_q, op2_b_q;
  logic [TAG_W-1:0] rd_tag_a_q, rd_tag_b_q;
  logic [4:0]       rd_a_q, rd_b_q;

  assign need_a   = wr_a && (rd_a != '0);
  assign need_b   = in_valid_b && wr_b && (rd_b != '0);
  assign need     = {1'b0, need_a} + {1'b0, need_b};
  assign in_ready = (!out_valid_q || out_ready) && space_ok && !flush;
  assign accept   = in_valid && in_ready;
  assign alloc_n  = accept ? need : 2'd0;
  assign tag_a    = tail;
  assign tag_b    = tail + TAG_W'(need_a);
  assign head_p1  = head + TAG_W'(1);

  // Retire only from registered complete bits, oldest first, stopping at the first gap.
  assign ret0       = !flush && (count != '0) && rrf_cmp_q[head];
  assign ret1       = ret0 && (count > (TAG_W+1)'(1)) && rrf_cmp_q[head_p1];
  assign retire_n   = {ret1, ret0 && !ret1};
  assign ret_rd0    = ret0 ? rrf_rd_q[head] : 5'd0;
  assign ret_rd1    = ret1 ? rrf_rd_q[head_p1] : 5'd0;
  assign retire_cnt = retire_n;
  assign retire_rd0 = ret_rd0;
  assign retire_rd1 = ret_rd1;

  rrf_alloc_ctrl #(.RRF_DEPTH(RRF_DEPTH)) u_alloc (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush),
    .need_i    (need),
    .alloc_n_i (alloc_n),
    .retire_n_i(retire_n),
    .head_o    (head),
    .tail_o    (tail),
    .count_o   (count),
    .space_ok_o(space_ok)
  );

  function automatic logic [XLEN:0] read_op(input logic [4:0] rs);
    logic [TAG_W-1:0] t;
    t = arf_tag_q[rs];
    if (rs == '0)                          return {1'b1, {XLEN{1'b0}}};
    else if (!arf_busy_q[rs])              return {1'b1, arf_val_q[rs]};
    else if (cmp_en[1] && cmp_tag1 == t)   return {1'b1, cmp_data1};
    else if (cmp_en[0] && cmp_tag0 == t)   return {1'b1, cmp_data0};
    else if (rrf_cmp_q[t])                 return {1'b1, rrf_val_q[t]};
    else                                   return {1'b0, XLEN'(t)};
  endfunction

  function automatic logic [XLEN:0] snoop(input logic [XLEN:0] op);
    if (!op[XLEN] && cmp_en[1] && cmp_tag1 == op[TAG_W-1:0]) return {1'b1, cmp_data1};
    if (!op[XLEN] && cmp_en[0] && cmp_tag0 == op[TAG_W-1:0]) return {1'b1, cmp_data0};
    return op;
  endfunction

  assign op1_a = read_op(rs1_a);
  assign op2_a = read_op(rs2_a);
  assign op1_b = (need_a && rs1_b == rd_a) ? {1'b0, XLEN'(tag_a)} : read_op(rs1_b);
  assign op2_b = (need_a && rs2_b == rd_a) ? {1'b0, XLEN'(tag_a)} : read_op(rs2_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arf_busy_q <= '0;
      for (int i = 0; i < NUM_ARCH; i++) begin
        arf_val_q[i] <= '0;
        arf_tag_q[i] <= '0;
      end
    end else if (flush) begin
      arf_busy_q <= '0;
    end else begin
      if (ret0) begin
        arf_val_q[ret_rd0] <= rrf_val_q[head];
        if (arf_tag_q[ret_rd0] == head) arf_busy_q[ret_rd0] <= 1'b0;
      end
      if (ret1) begin
        arf_val_q[ret_rd1] <= rrf_val_q[head_p1];
        if (arf_tag_q[ret_rd1] == head_p1) arf_busy_q[ret_rd1] <= 1'b0;
      end
      // Renames come last so a same-cycle remap overrides the retire-side busy clear.
      if (accept && need_a) begin
        arf_busy_q[rd_a] <= 1'b1;
        arf_tag_q[rd_a]  <= tag_a;
      end
      if (accept && need_b) begin
        arf_busy_q[rd_b] <= 1'b1;
        arf_tag_q[rd_b]  <= tag_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrf_cmp_q <= '0;
    end else if (flush) begin
      rrf_cmp_q <= '0;
    end else begin
      if (ret0)             rrf_cmp_q[head]     <= 1'b0;
      if (ret1)             rrf_cmp_q[head_p1]  <= 1'b0;
      if (accept && need_a) rrf_cmp_q[tag_a]    <= 1'b0;
      if (accept && need_b) rrf_cmp_q[tag_b]    <= 1'b0;
      if (cmp_en[0])        rrf_cmp_q[cmp_tag0] <= 1'b1;
      if (cmp_en[1])        rrf_cmp_q[cmp_tag1] <= 1'b1;
    end
  end

  // Entry payload is qualified by the complete bit, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept && need_a)      rrf_rd_q[tag_a]     <= rd_a;
    if (accept && need_b)      rrf_rd_q[tag_b]     <= rd_b;
    if (!flush && cmp_en[0])   rrf_val_q[cmp_tag0] <= cmp_data0;
    if (!flush && cmp_en[1])   rrf_val_q[cmp_tag1] <= cmp_data1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_valid_b_q <= 1'b0;
      op1_a_q       <= '0;
      op2_a_q       <= '0;
      op1_b_q       <= '0;
      op2_b_q       <= '0;
      rd_tag_a_q    <= '0;
      rd_tag_b_q    <= '0;
      rd_a_q        <= '0;
      rd_b_q        <= '0;
      out_wr_a_q    <= 1'b0;
      out_wr_b_q    <= 1'b0;
    end else if (flush) begin
      out_valid_q   <= 1'b0;
      out_valid_b_q <= 1'b0;
    end else if (accept) begin
      out_valid_q   <= 1'b1;
      out_valid_b_q <= in_valid_b;
      op1_a_q       <= op1_a;
      op2_a_q       <= op2_a;
      op1_b_q       <= op1_b;
      op2_b_q       <= op2_b;
      rd_tag_a_q    <= need_a ? tag_a : '0;
      rd_tag_b_q    <= need_b ? tag_b : '0;
      rd_a_q        <= rd_a;
      rd_b_q        <= rd_b;
      out_wr_a_q    <= wr_a;
      out_wr_b_q    <= in_valid_b && wr_b;
    end else if (out_ready) begin
      out_valid_q   <= 1'b0;
      out_valid_b_q <= 1'b0;
    end else begin
      op1_a_q <= snoop(op1_a_q);
      op2_a_q <= snoop(op2_a_q);
      op1_b_q <= snoop(op1_b_q);
      op2_b_q <= snoop(op2_b_q);
    end
  end

  assign out_valid    = out_valid_q;
  assign out_valid_b  = out_valid_b_q;
  assign out_op1_a    = op1_a_q;
  assign out_op2_a    = op2_a_q;
  assign out_op1_b    = op1_b_q;
  assign out_op2_b    = op2_b_q;
  assign out_rd_tag_a = rd_tag_a_q;
  assign out_rd_tag_b = rd_tag_b_q;
  assign out_rd_a     = rd_a_q;
  assign out_rd_b     = rd_b_q;
  assign out_wr_a     = out_wr_a_q;
  assign out_wr_b     = out_wr_b_q;

`ifdef RENAME_STATS_EN
  logic [31:0] stat_alloc_q, stat_stall_q, stat_full_q;
  logic [32:0] alloc_sum;

  assign alloc_sum = {1'b0, stat_alloc_q} + 33'(alloc_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_alloc_q <= '0;
      stat_stall_q <= '0;
      stat_full_q  <= '0;
    end else begin
      stat_alloc_q <= alloc_sum[32] ? '1 : alloc_sum[31:0];
      if (in_valid && !in_ready && stat_stall_q != '1)
        stat_stall_q <= stat_stall_q + 32'd1;
      if (count == (TAG_W+1)'(RRF_DEPTH) && stat_full_q != '1)
        stat_full_q <= stat_full_q + 32'd1;
    end
  end

  assign stat_alloc = stat_alloc_q;
  assign stat_stall = stat_stall_q;
  assign stat_full  = stat_full_q;
`endif

endmodule

// File: tb/tb_rename_stage_2w.sv
// tb/tb_rename_stage_2w.sv - directed self-checking bench for rename_stage_2w
module tb_rename_stage_2w;

  localparam logic [32:0] RDY0 = 33'h1_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_valid_b, in_ready;
  logic [4:0]  rs1_a, rs2_a, rd_a, rs1_b, rs2_b, rd_b;
  logic        wr_a, wr_b;
  logic [1:0]  cmp_en;
  logic [3:0]  cmp_tag0, cmp_tag1;
  logic [31:0] cmp_data0, cmp_data1;
  logic        out_valid, out_valid_b, out_ready;
  logic [32:0] out_op1_a, out_op2_a, out_op1_b, out_op2_b;
  logic [3:0]  out_rd_tag_a, out_rd_tag_b;
  logic [4:0]  out_rd_a, out_rd_b;
  logic        out_wr_a, out_wr_b;
  logic [1:0]  retire_cnt;
  logic [4:0]  retire_rd0, retire_rd1;
`ifdef RENAME_STATS_EN
  logic [31:0] stat_alloc, stat_stall, stat_full;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rename_stage_2w dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_valid_b(in_valid_b), .in_ready(in_ready),
    .rs1_a(rs1_a), .rs2_a(rs2_a), .rd_a(rd_a), .wr_a(wr_a),
    .rs1_b(rs1_b), .rs2_b(rs2_b), .rd_b(rd_b), .wr_b(wr_b),
    .cmp_en(cmp_en), .cmp_tag0(cmp_tag0), .cmp_tag1(cmp_tag1),
    .cmp_data0(cmp_data0), .cmp_data1(cmp_data1),
    .out_valid(out_valid), .out_valid_b(out_valid_b), .out_ready(out_ready),
    .out_op1_a(out_op1_a), .out_op2_a(out_op2_a), .out_op1_b(out_op1_b), .out_op2_b(out_op2_b),
    .out_rd_tag_a(out_rd_tag_a), .out_rd_tag_b(out_rd_tag_b),
    .out_rd_a(out_rd_a), .out_rd_b(out_rd_b), .out_wr_a(out_wr_a), .out_wr_b(out_wr_b),
    .retire_cnt(retire_cnt), .retire_rd0(retire_rd0), .retire_rd1(retire_rd1)
`ifdef RENAME_STATS_EN
    , .stat_alloc(stat_alloc), .stat_stall(stat_stall), .stat_full(stat_full)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_valid_b = 0; flush = 0;
    rs1_a = 0; rs2_a = 0; rd_a = 0; wr_a = 0;
    rs1_b = 0; rs2_b = 0; rd_b = 0; wr_b = 0;
    cmp_en = 0; cmp_tag0 = 0; cmp_tag1 = 0; cmp_data0 = 0; cmp_data1 = 0;
  endtask

  task automatic lane_a(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd, input logic wr);
    in_valid = 1; rs1_a = r1; rs2_a = r2; rd_a = rd; wr_a = wr;
  endtask

  task automatic lane_b(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd, input logic wr);
    in_valid_b = 1; rs1_b = r1; rs2_b = r2; rd_b = rd; wr_b = wr;
  endtask

  task automatic cmp(input logic [1:0] en, input logic [3:0] t0, input logic [31:0] d0,
                     input logic [3:0] t1, input logic [31:0] d1);
    cmp_en = en; cmp_tag0 = t0; cmp_data0 = d0; cmp_tag1 = t1; cmp_data1 = d1;
  endtask

  initial begin
    rst_n = 0; out_ready = 1; idle();
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_valid_b", out_valid_b, 0);
    check("rst_op1_a", out_op1_a, 0);
    check("rst_retire_cnt", retire_cnt, 0);
    rst_n = 1;

    lane_a(5, 0, 0, 0); #1;
    check("t1_in_ready", in_ready, 1);
    step();
    check("t1_op1_a", out_op1_a, RDY0);
    check("t1_op2_a", out_op2_a, RDY0);
    check("t1_out_valid", out_valid, 1);

    idle(); lane_a(0, 0, 3, 1); lane_b(3, 0, 0, 0); step();
    check("intra_op1_b", out_op1_b, 33'h0);
    check("intra_tag_a", out_rd_tag_a, 0);
    check("intra_valid_b", out_valid_b, 1);

    idle(); lane_a(3, 0, 0, 0); step();
    check("r3_busy", out_op1_a, 33'h0);
    cmp(2'b01, 0, 32'h11, 0, 0); step();
    check("r3_bypass", out_op1_a, 33'h1_0000_0011);
    idle(); #1;
    check("r3_retire_cnt", retire_cnt, 1);
    check("r3_retire_rd", retire_rd0, 3);
    lane_a(3, 0, 0, 0); step();
    check("r3_rrf_read", out_op1_a, 33'h1_0000_0011);
    check("r3_retire_done", retire_cnt, 0);
    step();
    check("r3_arf_read", out_op1_a, 33'h1_0000_0011);

    idle();
    for (int k = 0; k < 8; k++) begin
      lane_a(0, 0, 5'(8 + k), 1); lane_b(0, 0, 5'(16 + k), 1); #1;
      check("fill_in_ready", in_ready, 1);
      step();
      if (k == 0) begin
        check("fill_first_tag_a", out_rd_tag_a, 1);
        check("fill_first_tag_b", out_rd_tag_b, 2);
      end
    end
    check("fill_last_tag_a", out_rd_tag_a, 15);
    check("fill_wrap_tag_b", out_rd_tag_b, 0);

    idle(); lane_a(0, 0, 1, 1); #1;
    check("full_stall", in_ready, 0);
    idle(); lane_a(8, 0, 0, 0); #1;
    check("need0_in_ready", in_ready, 1);
    step();
    check("need0_op", out_op1_a, 33'h1);
    idle(); lane_a(0, 0, 1, 1); cmp(2'b01, 1, 32'h55, 0, 0); #1;
    check("full_stall2", in_ready, 0);
    step();
    cmp(2'b00, 0, 0, 0, 0); #1;
    check("head_retire_cnt", retire_cnt, 1);
    check("head_still_full", in_ready, 0);
    step();
    check("freed_in_ready", in_ready, 1);
    step();
    check("realloc_tag", out_rd_tag_a, 1);

    idle(); lane_a(11, 0, 0, 0); step();
    check("hold_op", out_op1_a, 33'h7);
    idle(); out_ready = 0; step();
    check("hold_keep", out_op1_a, 33'h7);
    check("hold_valid", out_valid, 1);
    cmp(2'b01, 7, 32'hDEAD, 0, 0); step();
    check("hold_snoop", out_op1_a, 33'h1_0000_DEAD);
    idle(); out_ready = 1; step();
    check("hold_drain", out_valid, 0);

    cmp(2'b11, 3, 32'h103, 4, 32'h104); step(); idle(); #1;
    check("inorder_block", retire_cnt, 0);
    cmp(2'b01, 2, 32'h102, 0, 0); step(); idle(); #1;
    check("ret2_cnt", retire_cnt, 2);
    check("ret2_rd0", retire_rd0, 16);
    check("ret2_rd1", retire_rd1, 9);
    step();
    check("ret1_cnt", retire_cnt, 1);
    check("ret1_rd0", retire_rd0, 17);
    step();
    check("ret0_cnt", retire_cnt, 0);

    cmp(2'b11, 5, 32'h105, 6, 32'h106); step();
    cmp(2'b11, 8, 32'h108, 9, 32'h109); step();
    cmp(2'b11, 10, 32'h10A, 11, 32'h10B); step();
    cmp(2'b11, 12, 32'h10C, 13, 32'h10D); step();
    cmp(2'b01, 14, 32'h10E, 0, 0); step();
    idle();
    repeat (8) step();
    check("stall_at_15", retire_cnt, 0);
    cmp(2'b11, 15, 32'h10F, 0, 32'h100); step(); idle(); #1;
    check("wrap_ret_cnt", retire_cnt, 2);
    check("wrap_ret_rd0", retire_rd0, 15);
    check("wrap_ret_rd1", retire_rd1, 23);
    step();
    check("wrap_ret_stop", retire_cnt, 0);

    lane_a(0, 0, 2, 1); lane_b(0, 0, 3, 1); step();
    lane_a(0, 0, 4, 1); lane_b(0, 0, 5, 1); step();
    idle(); out_ready = 0; flush = 1; #1;
    check("flush_in_ready", in_ready, 0);
    step();
    flush = 0;
    check("flush_out_valid", out_valid, 0);
    out_ready = 1;
    lane_a(3, 15, 6, 1); lane_b(6, 23, 6, 1); #1;
    check("post_flush_ready", in_ready, 1);
    step();
    check("pf_op1_a", out_op1_a, 33'h1_0000_0011);
    check("pf_op2_a", out_op2_a, 33'h1_0000_010F);
    check("pf_op1_b", out_op1_b, 33'h0);
    check("pf_op2_b", out_op2_b, 33'h1_0000_0100);
    check("pf_tag_a", out_rd_tag_a, 0);
    check("pf_tag_b", out_rd_tag_b, 1);
    idle(); lane_a(6, 1, 0, 0); step();
    check("rdb_wins_map", out_op1_a, 33'h1);
    check("flush_busy_clear", out_op2_a, RDY0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
